// File: rtl/dropout_mask_gen.sv
// Per-neuron dropout keep/drop mask generator: 16-bit Galois LFSR nibbles vs. rate, valid/ready output.
// Optional DROPOUT_MASK_STATS_EN adds drop_count, a saturating tally of dropped neurons over accepted masks.
module dropout_mask_gen #(
   parameter int                N_NEURONS  = 8,
   parameter int                LFSR_W     = 16,
   parameter logic [LFSR_W-1:0] RESET_SEED = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 seed_load,
   input  logic [LFSR_W-1:0]    seed_data,
   input  logic [3:0]           rate,
   output logic                 mask_valid,
   input  logic                 mask_ready,
   output logic [N_NEURONS-1:0] mask,
   output logic                 busy
`ifdef DROPOUT_MASK_STATS_EN
   ,
   output logic [15:0]          drop_count
`endif
);

   localparam int                CNT_W = $clog2(N_NEURONS);
   localparam logic [LFSR_W-1:0] POLY  = LFSR_W'(16'hB400);

   typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;

   state_t                 state_q;
   logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [N_NEURONS-1:0]   mask_q;
   logic [3:0]             rate_q;
   logic                   valid_q, busy_q;
   logic                   keep_d;

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? POLY : '0);
      keep_d = (lfsr_d[3:0] >= rate_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lfsr_q  <= RESET_SEED;
         cnt_q   <= '0;
         mask_q  <= '0;
         rate_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else if (seed_load) begin
         // All-zero seed would lock the LFSR, so it falls back to RESET_SEED.
         lfsr_q  <= (seed_data == '0) ? RESET_SEED : seed_data;
         state_q <= IDLE;
         cnt_q   <= '0;
         mask_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ena) begin
                  rate_q  <= rate;
                  cnt_q   <= '0;
                  state_q <= GEN;
                  busy_q  <= 1'b1;
               end
            end
            GEN: begin
               if (ena) begin
                  lfsr_q        <= lfsr_d;
                  mask_q[cnt_q] <= keep_d;
                  if (cnt_q == CNT_W'(N_NEURONS - 1)) begin
                     state_q <= HOLD;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (mask_ready) begin
                  valid_q <= 1'b0;
                  if (ena) begin
                     rate_q  <= rate;
                     cnt_q   <= '0;
                     state_q <= GEN;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mask_valid = valid_q;
   assign mask       = mask_q;
   assign busy       = busy_q;

`ifdef DROPOUT_MASK_STATS_EN
   localparam int ZW = $clog2(N_NEURONS + 1);

   logic [15:0] drop_count_q;
   logic [ZW-1:0] zeros_d;
   logic [16:0] sum_d;

   always_comb begin
      zeros_d = ZW'(N_NEURONS - $countones(mask_q));
      sum_d   = {1'b0, drop_count_q} + 17'(zeros_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count_q <= '0;
      end else if (seed_load) begin
         drop_count_q <= '0;
      end else if (state_q == HOLD && valid_q && mask_ready) begin
         drop_count_q <= sum_d[16] ? '1 : sum_d[15:0];
      end
   end

   assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_dropout_mask_gen.sv
// Self-checking bench for dropout_mask_gen: vector table, corner sequences and randomized runs vs. an LFSR model.
module tb_dropout_mask_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic        seed_load;
   logic [15:0] seed_data;
   logic [3:0]  rate;
   logic        mask_valid;
   logic        mask_ready;
   logic [7:0]  mask;
   logic        busy;
`ifdef DROPOUT_MASK_STATS_EN
   logic [15:0] drop_count;
`endif

   int checks   = 0;
   int failures = 0;

   logic [15:0] mdl_lfsr;

   dropout_mask_gen #(
      .N_NEURONS (8),
      .LFSR_W    (16),
      .RESET_SEED(16'hACE1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .seed_load (seed_load),
      .seed_data (seed_data),
      .rate      (rate),
      .mask_valid(mask_valid),
      .mask_ready(mask_ready),
      .mask      (mask),
      .busy      (busy)
`ifdef DROPOUT_MASK_STATS_EN
      ,
      .drop_count(drop_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] seed;
      logic [3:0]  rate;
      logic [7:0]  exp_mask;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: divide-by-two plus feedback XOR, one step per neuron.
   function automatic logic [15:0] model_step(input logic [15:0] s);
      logic [15:0] n;
      n = s / 16'd2;
      if (s % 2 == 1) n = n ^ 16'hB400;
      return n;
   endfunction

   function automatic logic [7:0] model_mask(input logic [3:0] r);
      logic [7:0] m;
      m = 8'h00;
      for (int i = 0; i < 8; i++) begin
         mdl_lfsr = model_step(mdl_lfsr);
         if ((mdl_lfsr % 16) >= r) m = m | (8'h01 << i);
      end
      return m;
   endfunction

   task automatic load_seed(input logic [15:0] s);
      seed_load = 1'b1;
      seed_data = s;
      tick();
      seed_load = 1'b0;
      mdl_lfsr  = (s == 16'h0) ? 16'hACE1 : s;
      check("load_valid", mask_valid, 1'b0);
      check("load_busy", busy, 1'b0);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!mask_valid && n < 100) begin
         tick();
         n++;
      end
      check("wait_valid", mask_valid, 1'b1);
   endtask

   task automatic accept();
      mask_ready = 1'b1;
      tick();
      mask_ready = 1'b0;
      check("accept_drop", mask_valid, 1'b0);
   endtask

   initial begin
      vec_t        vecs[5];
      int          n, bad;
      logic [7:0]  held, exp_m;
      logic [7:0]  seq_a[3], seq_b[3];
      logic [31:0] rnd;
      logic [3:0]  r;

      vecs[0] = '{16'h0000, 4'd0,  8'hFF};
      vecs[1] = '{16'h0000, 4'd1,  8'hFE};
      vecs[2] = '{16'hACE1, 4'd15, 8'h00};
      vecs[3] = '{16'hACE1, 4'd9,  8'h4C};
      vecs[4] = '{16'h1234, 4'd0,  8'hFF};

      rst_n = 1'b0; ena = 1'b0; seed_load = 1'b0; seed_data = '0;
      rate = '0; mask_ready = 1'b0;
      #12;
      check("rst_valid", mask_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_mask", mask, 8'h00);
`ifdef DROPOUT_MASK_STATS_EN
      check("rst_drop_count", drop_count, 16'h0);
`endif

      // rate=0 latency and back-to-back throughput
      @(negedge clk);
      rst_n = 1'b1; rate = 4'd0; ena = 1'b1; mask_ready = 1'b1;
      tick();
      check("gen_entry_busy", busy, 1'b1);
      n = 0;
      do begin tick(); n++; end while (!mask_valid && n < 100);
      check("first_latency", n, 8);
      check("rate0_mask", mask, 8'hFF);
      n = 0;
      do begin tick(); n++; end while (!mask_valid && n < 100);
      check("period", n, 9);
      check("rate0_mask2", mask, 8'hFF);
      mask_ready = 1'b0;

      // vector table
      for (int i = 0; i < 5; i++) begin
         ena  = 1'b1;
         rate = vecs[i].rate;
         load_seed(vecs[i].seed);
         wait_valid(n);
         check("vec_latency", n, 9);
         check($sformatf("vec%0d_mask", i), mask, vecs[i].exp_mask);
         accept();
      end

      // hold stability with rate churn; new rate applies to next mask
      rate = 4'd4;
      load_seed(16'hBEEF);
      wait_valid(n);
      check("hold_mask", mask, model_mask(4'd4));
      held = mask;
      bad  = 0;
      for (int k = 0; k < 20; k++) begin
         rate = 4'($urandom);
         tick();
         if (!mask_valid || mask !== held) bad++;
      end
      check("hold_stable", bad, 0);
      rate = 4'd15;
      accept();
      wait_valid(n);
      check("b2b_latency", n, 8);
      check("new_rate_mask", mask, model_mask(4'd15));
      ena = 1'b0;
      accept();
      tick();
      check("idle_busy", busy, 1'b0);
      check("idle_valid", mask_valid, 1'b0);

      // ena pause at cnt=3
      ena  = 1'b1;
      rate = 4'd7;
      load_seed(16'h5A5A);
      tick();
      n = 0;
      repeat (3) begin tick(); n++; end
      ena = 1'b0;
      repeat (5) begin tick(); n++; end
      check("pause_busy", busy, 1'b1);
      check("pause_valid", mask_valid, 1'b0);
      ena = 1'b1;
      while (!mask_valid && n < 100) begin tick(); n++; end
      check("pause_latency", n, 13);
      check("pause_mask", mask, model_mask(4'd7));

      // zero seed_load mid-GEN at cnt=5
      rate = 4'd5;
      load_seed(16'h1357);
      tick();
      repeat (5) tick();
      load_seed(16'h0000);
      wait_valid(n);
      check("reseed_latency", n, 9);
      exp_m = model_mask(4'd5);
      check("reseed_mask", mask, exp_m);
      accept();

      // reproducibility of seed 0x1234
      rate = 4'd6;
      mask_ready = 1'b0;
      load_seed(16'h1234);
      mask_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_valid(n);
         seq_a[k] = mask;
         check("seqA_model", mask, model_mask(4'd6));
         tick();
      end
      mask_ready = 1'b0;
      load_seed(16'h1234);
      mask_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_valid(n);
         seq_b[k] = mask;
         tick();
      end
      mask_ready = 1'b0;
      for (int k = 0; k < 3; k++) check("seq_repeat", seq_b[k], seq_a[k]);

      // async reset in GEN and in HOLD
      rate = 4'd3;
      load_seed(16'h0F0F);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check("arst_gen_busy", busy, 1'b0);
      check("arst_gen_mask", mask, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      mdl_lfsr = 16'hACE1;
      wait_valid(n);
      check("post_arst_mask", mask, model_mask(4'd3));
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_hold_valid", mask_valid, 1'b0);
      check("arst_hold_mask", mask, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // randomized runs, rate churn after GEN entry
      for (int it = 0; it < 12; it++) begin
         rnd = $urandom;
         r   = 4'($urandom_range(0, 15));
         ena = 1'b1;
         rate = r;
         load_seed(rnd[15:0]);
         tick();
         rate = 4'($urandom);
         wait_valid(n);
         exp_m = model_mask(r);
         check($sformatf("rand%0d_mask", it), mask, exp_m);
         bad = 0;
         repeat ($urandom_range(0, 4)) begin
            tick();
            if (!mask_valid || mask !== exp_m) bad++;
         end
         check("rand_hold", bad, 0);
         accept();
      end

`ifdef DROPOUT_MASK_STATS_EN
      begin
         int sum;
         sum  = 0;
         rate = 4'd8;
         load_seed(16'h2468);
         check("stats_clear0", drop_count, 16'h0);
         for (int k = 0; k < 4; k++) begin
            wait_valid(n);
            exp_m = model_mask(4'd8);
            check("stats_mask", mask, exp_m);
            sum += 8 - $countones(exp_m);
            accept();
         end
         check("drop_count", drop_count, sum);
         load_seed(16'h2468);
         check("drop_count_clear", drop_count, 16'h0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
